seq_shift_add_mul: RTL and testbench
====================================

# seq_shift_add_mul

- Sequential unsigned shift-and-add multiplier: WIDTH×WIDTH operands in, 2·WIDTH product out, one partial-product bit per clock.
- Arithmetic companion to the ripple subtractor datapath: the subtractor takes operands apart, this block builds them back up through repeated addition.
- Sits beside the combinational add/sub units.
- Uses a start/ready/done handshake, so a controller FSM can launch an operation and poll for completion.

## Interface
- WIDTH, 4, operand width in bits (legal 2..16); product width is 2·WIDTH.
- clk  input  1  rising-edge clock, sole clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin; sampled only when ready=1.
- A1  input  WIDTH  multiplicand; sampled on the accepting edge.
- B1  input  WIDTH  multiplier; sampled on the accepting edge.
- ready  output  1  high only in IDLE.
- busy  output  1  high in RUN.
- done  output  1  single-cycle pulse, high only in DONE.
- P  output  2·WIDTH  product; holds its value until the next accepted start.
- Reset values: ready=1, busy=0, done=0, P=0.

## Operation
- States: IDLE, RUN, DONE; encoded 2 bits; reset → IDLE.
- IDLE, start=1:
  - Latch mcand←A1.
  - Acc←{WIDTH'b0, B1}: low half holds the multiplier, high half is zero.
  - cnt←WIDTH.
  - Go to RUN.
- IDLE, start=0: stay in IDLE; registers hold.
- RUN, each cycle:
  - {c, sum} = acc[hi] + (acc[0] ? mcand : 0), a WIDTH-bit add with carry-out c.
  - acc ← {c, sum, acc[lo]} >> 1, i.e. a (2·WIDTH+1)-bit right shift truncated to 2·WIDTH.
  - cnt ← cnt−1.
  - When cnt reaches 1 on this edge, go to DONE and copy the final acc into P on the same edge.
- DONE: done=1 for exactly one cycle, then unconditionally go to IDLE.
- start is ignored in RUN and DONE. There is no queueing; the controller must wait for ready.
- A1/B1 changes after the accepting edge have no effect.
- The product is exact: no overflow is possible, since (2^W−1)² < 2^(2W).
- Reset asserted in any state:
  - Next state IDLE, P=0, done=0, acc=0, cnt=0.
  - The in-flight operation is discarded.
- rst has priority over start on the same edge.

## Timing
- Start accepted at edge k.
- RUN occupies edges k+1 … k+WIDTH.
- done=1 and P valid during the cycle after edge k+WIDTH.
- ready=1 again after edge k+WIDTH+1.
- Latency start→done: WIDTH+1 cycles. Initiation interval: WIDTH+2 cycles.
- Back-to-back: start held high through DONE is accepted on the first IDLE edge.
- P changes only on the edge entering DONE, or on reset.
- All outputs are registered or decoded from the state register; no combinational path from start, A1 or B1 to outputs.

## Configuration
- ZERO_SKIP_EN defined:
  - In IDLE with start=1, if A1==0 or B1==0, go directly to DONE and load P←0 on that edge.
  - done then appears 1 cycle after acceptance; initiation interval is 2.
- ZERO_SKIP_EN undefined:
  - Zero operands take the full WIDTH-cycle RUN path.
  - The result is identical (P=0); only latency differs.

## Structure
- Package seq_mul_pkg:
  - State enum (IDLE/RUN/DONE).
  - Localparam for default WIDTH.
  - Function returning the product width.
- Sub-module ripple_add_n (parameter N=WIDTH):
  - N-bit ripple-carry adder with CI/CO, built from full-adder cells in the same style as the existing four-bit adder.
  - Instantiated once with CI=0 for the accumulate step.
- Top: state register, counter, accumulator/shift register, P output register.

## Test plan
- Reset then start, A1=15, B1=15, WIDTH=4 → done in cycle 5 after acceptance, P=0xE1; ready returns the next cycle.
- A1=3, B1=5 → P=0x0F. A1=9, B1=6 → P=0x36. P holds 0x36 until the next start.
- A1=0, B1=9 → P=0. Done latency is 1 cycle with ZERO_SKIP_EN and 5 cycles without.
- Start pulsed with A1=2, B1=2 during RUN of a 7×7 operation → ignored; P=0x31, exactly one done pulse.
- rst asserted at the third RUN cycle of 12×11 → next cycle ready=1, busy=0, done=0, P=0. A fresh 12×11 then yields P=0x84.
- start held high continuously with A1=B1=15 → done pulses every 6 cycles, each with P=0xE1.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// the controller state encoding, the default operand width and a
// helper that derives the product width from the operand width.
package seq_mul_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/ripple_add_n.sv
// N-bit ripple-carry adder with carry-in and carry-out, built as a chain
// of full-adder cells (sum = a^b^c, carry = ab | c(a^b)).
module ripple_add_n #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);

  logic carry;

  // Full-adder cell per bit, carry rippling from bit 0 upward.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    s     = '0;
    carry = ci;
    for (int i = 0; i < N; i++) begin
      // NOTE: carry is a blocking temporary, so each cell sees the carry of the cell below it.
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    co = carry;
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Sequential unsigned shift-and-add multiplier with a start/ready/done
// handshake. One multiplier bit is consumed per clock in RUN; the product
// register P only changes on the edge entering DONE or on reset.
// Optional feature macro: ZERO_SKIP_EN -- when defined, a zero operand
// goes straight from IDLE to DONE with P=0, skipping the RUN phase.
module seq_shift_add_mul
  import seq_mul_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [WIDTH-1:0]               A1,
  input  logic [WIDTH-1:0]               B1,
  output logic                           ready,
  output logic                           busy,
  output logic                           done,
  output logic [prod_width(WIDTH)-1:0]   P
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  state_t          state;
  state_t          state_next;
  logic [PW-1:0]   acc;
  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic [PW-1:0]    acc_shift;
  logic             zero_skip;
  logic             last_step;

`ifdef ZERO_SKIP_EN
  assign zero_skip = (A1 == '0) || (B1 == '0);
`else
  assign zero_skip = 1'b0;
`endif

  // Add the multiplicand into the high half only when the current multiplier bit is set.
  assign addend = acc[0] ? mcand : '0;

  ripple_add_n #(.N(WIDTH)) u_add (
    .a  (acc[PW-1:WIDTH]),
    .b  (addend),
    .ci (1'b0),
    .s  (sum),
    .co (carry_out)
  );

  // Carry becomes the new MSB; the consumed multiplier bit falls off the bottom.
  assign acc_shift = {carry_out, sum, acc[WIDTH-1:1]};
  assign last_step = (cnt == CW'(1));

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decode for the IDLE -> RUN -> DONE -> IDLE sequence.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = zero_skip ? S_DONE : S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: operand capture, shift-add iterations and product capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      mcand <= '0;
      cnt   <= '0;
      P     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mcand <= A1;
            acc   <= {{WIDTH{1'b0}}, B1};
            cnt   <= CW'(WIDTH);
            if (zero_skip) P <= '0;
          end
        end
        S_RUN: begin
          acc <= acc_shift;
          cnt <= cnt - CW'(1);
          if (last_step) P <= acc_shift;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul (WIDTH=4). A timeline model
// (acceptance edge + latency + plain multiplication) predicts ready/busy/
// done/P every cycle; directed operations pin literal products/latencies,
// then randomized start/operand/reset traffic runs against the model.
module tb_seq_shift_add_mul;

  localparam int W  = 4;
  localparam int PW = 2 * W;
`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  A1;
  logic [W-1:0]  B1;
  logic          ready;
  logic          busy;
  logic          done;
  logic [PW-1:0] P;

  int n_cmp = 0;
  int n_bad = 0;

  seq_shift_add_mul #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A1    (A1),
    .B1    (B1),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .P     (P)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int            edge_n = 0;
  int            last_e = 0;
  bit            m_valid = 1'b0;
  bit            in_fl = 1'b0;
  int            acc_e = 0;
  int            lat = 0;
  logic [PW-1:0] m_prod = '0;
  logic [PW-1:0] m_P = '0;

  always @(posedge clk) begin
    if (rst) begin
      in_fl   = 1'b0;
      m_P     = '0;
      m_valid = 1'b1;
    end else if (!in_fl) begin
      if (start) begin
        in_fl  = 1'b1;
        acc_e  = edge_n;
        m_prod = PW'(int'(A1) * int'(B1));
        lat    = (ZS && (A1 == 0 || B1 == 0)) ? 0 : W;
        if (lat == 0) m_P = m_prod;
      end
    end else begin
      if (edge_n == acc_e + lat)     m_P   = m_prod;
      if (edge_n == acc_e + lat + 1) in_fl = 1'b0;
    end
    last_e = edge_n;
    edge_n++;
  end

  always @(negedge clk) begin
    bit e_ready;
    bit e_busy;
    bit e_done;
    int d;
    if (m_valid) begin
      e_ready = !in_fl;
      e_busy  = 1'b0;
      e_done  = 1'b0;
      if (in_fl) begin
        d      = last_e - acc_e;
        e_busy = (d < lat);
        e_done = (d == lat);
      end
      check("ready", 32'(ready), 32'(e_ready));
      check("busy",  32'(busy),  32'(e_busy));
      check("done",  32'(done),  32'(e_done));
      check("P",     32'(P),     32'(m_P));
    end
  end

  // ---------------- directed helpers ----------------
  task automatic wait_ready();
    for (int i = 0; i < 20 && !ready; i++) @(negedge clk);
    check("ready_wait", 32'(ready), 32'd1);
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [PW-1:0] exp_p, input int exp_lat, input string name);
    int d;
    wait_ready();
    start = 1'b1; A1 = a; B1 = b;
    @(negedge clk);
    start = 1'b0;
    d = 0;
    while (!done && d < 30) begin
      @(negedge clk);
      d++;
    end
    check({name, "_latency"}, 32'(d + 1), 32'(exp_lat));
    check({name, "_P"},       32'(P),     32'(exp_p));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int prev;
    logic [PW-1:0] p_at_done;

    rst = 1'b1; start = 1'b0; A1 = '0; B1 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_done",  32'(done),  32'd0);
    check("rst_P",     32'(P),     32'd0);
    rst = 1'b0;

    do_op(4'd15, 4'd15, 8'hE1, 5, "15x15");
    @(negedge clk);
    check("15x15_ready_back", 32'(ready), 32'd1);

    do_op(4'd3, 4'd5, 8'h0F, 5, "3x5");
    do_op(4'd9, 4'd6, 8'h36, 5, "9x6");
    A1 = 4'd1; B1 = 4'd1;
    repeat (3) @(negedge clk);
    check("9x6_hold", 32'(P), 32'h36);

    do_op(4'd0, 4'd9, 8'h00, ZS ? 1 : 5, "0x9");

    // start pulse during RUN must be ignored
    wait_ready();
    start = 1'b1; A1 = 4'd7; B1 = 4'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; A1 = 4'd2; B1 = 4'd2;
    @(negedge clk);
    start = 1'b0;
    pulses = 0; p_at_done = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        p_at_done = P;
      end
      @(negedge clk);
    end
    check("7x7_pulses", 32'(pulses), 32'd1);
    check("7x7_P", 32'(p_at_done), 32'h31);

    // reset in the third RUN cycle discards the operation
    wait_ready();
    start = 1'b1; A1 = 4'd12; B1 = 4'd11;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_busy",  32'(busy),  32'd0);
    check("abort_done",  32'(done),  32'd0);
    check("abort_P",     32'(P),     32'd0);
    rst = 1'b0;
    do_op(4'd12, 4'd11, 8'h84, 5, "12x11");

    // start held high: done every WIDTH+2 cycles
    wait_ready();
    start = 1'b1; A1 = 4'd15; B1 = 4'd15;
    prev = -1; pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        check("b2b_P", 32'(P), 32'hE1);
        if (prev >= 0) check("b2b_gap", 32'(i - prev), 32'd6);
        prev = i;
      end
    end
    check("b2b_pulses", 32'(pulses), 32'd6);
    start = 1'b0;
    repeat (8) @(negedge clk);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 79) == 0);
      start = ($urandom_range(0, 2) != 0);
      A1    = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      B1    = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      @(negedge clk);
    end
    rst = 1'b0; start = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
